// File: rtl/layer_sequencer.sv
// Sequences one inference through LAYER_NB dense layers: clear, run, wait on sticky done, with per-layer watchdog.
// Optional SEQ_PERF_EN adds the o_cycle_count port reporting total busy cycles of the last inference.
module layer_sequencer #(
    parameter int LAYER_NB  = 3,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_WIDTH = 16,
    localparam int CUR_W    = (LAYER_NB > 1) ? $clog2(LAYER_NB) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [LAYER_NB-1:0]  i_layer_done,
    output logic [LAYER_NB-1:0]  o_layer_en,
    output logic [LAYER_NB-1:0]  o_layer_reset,
    output logic [CUR_W-1:0]     o_cur_layer,
    output logic                 o_busy,
    output logic                 o_net_done,
    output logic                 o_error
`ifdef SEQ_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] o_cycle_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE, S_ERROR} state_t;

    localparam logic [CUR_W-1:0]     LAST_LAYER = CUR_W'(LAYER_NB - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LIMIT   = CNT_WIDTH'(TIMEOUT);

    state_t                r_state, w_state_nxt;
    logic [CUR_W-1:0]      r_cur, w_cur_nxt, w_cur_inc;
    logic [CNT_WIDTH-1:0]  r_wd, w_wd_nxt;
    logic [LAYER_NB-1:0]   r_en, w_en_nxt;
    logic [LAYER_NB-1:0]   r_rst, w_rst_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_net_done, w_net_done_nxt;
    logic                  r_err, w_err_nxt;
    logic [LAYER_NB-1:0]   w_run_mask;
    logic                  w_accept;
    logic                  w_finish;

    // Every layer up to the current one stays enabled so upstream outputs remain driven.
    for (genvar g = 0; g < LAYER_NB; g++) begin : g_mask
        assign w_run_mask[g] = (r_cur >= CUR_W'(g));
    end

    assign w_cur_inc = r_cur + CUR_W'(1);
    assign w_accept  = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_finish  = (r_state == S_RUN) && (w_state_nxt == S_DONE || w_state_nxt == S_ERROR);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_wd       <= '0;
            r_en       <= '0;
            r_rst      <= '0;
            r_busy     <= 1'b0;
            r_net_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_wd       <= w_wd_nxt;
            r_en       <= w_en_nxt;
            r_rst      <= w_rst_nxt;
            r_busy     <= w_busy_nxt;
            r_net_done <= w_net_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_wd_nxt       = r_wd;
        w_en_nxt       = r_en;
        w_rst_nxt      = '0;
        w_busy_nxt     = r_busy;
        w_net_done_nxt = 1'b0;
        w_err_nxt      = r_err;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_accept) begin
                    w_state_nxt = S_CLEAR;
                    w_cur_nxt   = '0;
                    w_wd_nxt    = '0;
                    w_en_nxt    = '0;
                    w_rst_nxt   = LAYER_NB'(1);
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_RUN;
                w_en_nxt    = w_run_mask;
                w_wd_nxt    = CNT_WIDTH'(1);
            end
            S_RUN: begin
                // A done seen on the timeout cycle still counts as success.
                if (i_layer_done[r_cur]) begin
                    if (r_cur == LAST_LAYER) begin
                        w_state_nxt    = S_DONE;
                        w_en_nxt       = '1;
                        w_net_done_nxt = 1'b1;
                        w_busy_nxt     = 1'b0;
                    end else begin
                        w_state_nxt = S_CLEAR;
                        w_cur_nxt   = w_cur_inc;
                        w_wd_nxt    = '0;
                        w_rst_nxt   = LAYER_NB'(1) << w_cur_inc;
                    end
                end else if (r_wd == WD_LIMIT) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = 1'b1;
                    w_en_nxt    = '0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_wd_nxt = r_wd + CNT_WIDTH'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_layer_en    = r_en;
    assign o_layer_reset = r_rst;
    assign o_cur_layer   = r_cur;
    assign o_busy        = r_busy;
    assign o_net_done    = r_net_done;
    assign o_error       = r_err;

`ifdef SEQ_PERF_EN
    logic [CNT_WIDTH-1:0] r_perf_cnt, r_cycle_count, w_perf_inc;

    assign w_perf_inc = (&r_perf_cnt) ? r_perf_cnt : r_perf_cnt + CNT_WIDTH'(1);

    // The final busy cycle is folded in at latch time, hence the incremented value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_cnt    <= '0;
            r_cycle_count <= '0;
        end else begin
            if (w_accept)
                r_perf_cnt <= '0;
            else if (r_busy)
                r_perf_cnt <= w_perf_inc;
            if (w_finish)
                r_cycle_count <= w_perf_inc;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    logic w_unused;
    assign w_unused = w_finish;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: behavioural sticky-done layer models, expected pulse events queued at start.
module tb_layer_sequencer;
    localparam int N  = 3;
    localparam int TO = 16;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_start = 1'b0;
    logic [N-1:0] i_layer_done;
    logic [N-1:0] o_layer_en, o_layer_reset;
    logic [1:0]   o_cur_layer;
    logic         o_busy, o_net_done, o_error;
`ifdef SEQ_PERF_EN
    logic [CW-1:0] o_cycle_count;
`endif

    layer_sequencer #(.LAYER_NB(N), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_layer_done(i_layer_done),
        .o_layer_en(o_layer_en), .o_layer_reset(o_layer_reset), .o_cur_layer(o_cur_layer),
        .o_busy(o_busy), .o_net_done(o_net_done), .o_error(o_error)
`ifdef SEQ_PERF_EN
        , .o_cycle_count(o_cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Layer model: done goes high (sticky) during the k-th enabled cycle after its clear; k=0 never.
    int           kcfg [N];
    int           mcnt [N];
    logic [N-1:0] mdone = '0;
    logic [N-1:0] force_mask = '0;
    assign i_layer_done = mdone | force_mask;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (i_reset || o_layer_reset[i]) begin
                mcnt[i]  <= 0;
                mdone[i] <= 1'b0;
            end else if (o_layer_en[i]) begin
                mcnt[i] <= mcnt[i] + 1;
                if (kcfg[i] != 0 && mcnt[i] + 1 == kcfg[i]) mdone[i] <= 1'b1;
            end
        end
    end

    typedef struct { int c; logic [N-1:0] lrst; logic nd; } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input int c, input logic [N-1:0] r, input logic nd);
        ev_t e;
        e.c = c; e.lrst = r; e.nd = nd;
        exp_q.push_back(e);
    endtask

    // Every layer_reset or net_done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (o_layer_reset != '0 || o_net_done) begin
            ev_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: cyc=%0d layer_reset=%b net_done=%b, required no event", cyc, o_layer_reset, o_net_done);
            end else begin
                e = exp_q.pop_front();
                if (e.c !== cyc || e.lrst !== o_layer_reset || e.nd !== o_net_done) begin
                    n_bad++;
                    $display("FAIL sb_event: got cyc=%0d lrst=%b nd=%b, required cyc=%0d lrst=%b nd=%b",
                             cyc, o_layer_reset, o_net_done, e.c, e.lrst, e.nd);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_start(output int t0);
        @(negedge clk);
        t0 = cyc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic push_nominal(input int t0);
        push_ev(t0 + 1,  3'b001, 1'b0);
        push_ev(t0 + 6,  3'b010, 1'b0);
        push_ev(t0 + 11, 3'b100, 1'b0);
        push_ev(t0 + 16, 3'b000, 1'b1);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({o_layer_en, o_layer_reset, o_cur_layer, o_busy, o_net_done, o_error} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: en=%b rst=%b cur=%0d busy=%b nd=%b err=%b, required all zero",
                     o_layer_en, o_layer_reset, o_cur_layer, o_busy, o_net_done, o_error);
        end
`ifdef SEQ_PERF_EN
        n_cmp++;
        if (o_cycle_count !== '0) begin
            n_bad++;
            $display("FAIL reset_cycle_count: got %0d required 0", o_cycle_count);
        end
`endif
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int t0;
        logic exp_busy;
        kcfg = '{4, 4, 4};
        @(negedge clk);
        push_nominal(cyc + 1);
        do_start(t0);
        for (int c = t0 + 1; c <= t0 + 18; c++) begin
            wait_until(c);
            exp_busy = (c >= t0 + 1) && (c <= t0 + 15);
            n_cmp++;
            if (o_busy !== exp_busy) begin
                n_bad++;
                $display("FAIL nominal_busy: cyc+%0d got %b required %b", c - t0, o_busy, exp_busy);
            end
            if (c == t0 + 1 || c == t0 + 2 || c == t0 + 17) begin
                n_cmp++;
                if (o_layer_en !== (c == t0 + 1 ? 3'b000 : c == t0 + 2 ? 3'b001 : 3'b111)) begin
                    n_bad++;
                    $display("FAIL nominal_en: cyc+%0d got %b", c - t0, o_layer_en);
                end
            end
        end
        n_cmp++;
        if (o_error !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL nominal_end: error=%b pending=%0d, required 0/0", o_error, exp_q.size());
        end
`ifdef SEQ_PERF_EN
        n_cmp++;
        if (o_cycle_count !== 16'd15) begin
            n_bad++;
            $display("FAIL nominal_cycle_count: got %0d required 15", o_cycle_count);
        end
`endif
    endtask

    task automatic test_timeout();
        int t0;
        kcfg = '{4, 0, 4};
        @(negedge clk);
        push_ev(cyc + 2, 3'b001, 1'b0);
        push_ev(cyc + 7, 3'b010, 1'b0);
        do_start(t0);
        wait_until(t0 + 22);
        n_cmp++;
        if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_early: error=%b busy=%b, required 0/1", o_error, o_busy);
        end
        wait_until(t0 + 23);
        n_cmp++;
        if (o_error !== 1'b1 || o_cur_layer !== 2'd1 || o_layer_en !== 3'b000 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_error: err=%b cur=%0d en=%b busy=%b, required 1/1/000/0",
                     o_error, o_cur_layer, o_layer_en, o_busy);
        end
`ifdef SEQ_PERF_EN
        n_cmp++;
        if (o_cycle_count !== 16'd22) begin
            n_bad++;
            $display("FAIL timeout_cycle_count: got %0d required 22", o_cycle_count);
        end
`endif
        wait_until(t0 + 26);
        n_cmp++;
        if (o_error !== 1'b1 || o_cur_layer !== 2'd1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_hold: err=%b cur=%0d pending=%0d", o_error, o_cur_layer, exp_q.size());
        end
        kcfg = '{4, 4, 4};
        @(negedge clk);
        push_nominal(cyc + 1);
        do_start(t0);
        n_cmp++;
        if (o_error !== 1'b0 || o_cur_layer !== 2'd0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL retry_start: err=%b cur=%0d busy=%b, required 0/0/1", o_error, o_cur_layer, o_busy);
        end
        wait_until(t0 + 17);
        n_cmp++;
        if (o_layer_en !== 3'b111 || o_error !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL retry_end: en=%b err=%b pending=%0d", o_layer_en, o_error, exp_q.size());
        end
    endtask

    task automatic test_done_timeout_tie();
        int t0;
        kcfg = '{16, 4, 4};
        @(negedge clk);
        push_ev(cyc + 2,  3'b001, 1'b0);
        push_ev(cyc + 19, 3'b010, 1'b0);
        push_ev(cyc + 24, 3'b100, 1'b0);
        push_ev(cyc + 29, 3'b000, 1'b1);
        do_start(t0);
        wait_until(t0 + 18);
        n_cmp++;
        if (o_error !== 1'b0 || o_cur_layer !== 2'd1) begin
            n_bad++;
            $display("FAIL tie_advance: err=%b cur=%0d, required 0/1", o_error, o_cur_layer);
        end
        wait_until(t0 + 30);
        n_cmp++;
        if (o_error !== 1'b0 || o_layer_en !== 3'b111 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL tie_end: err=%b en=%b pending=%0d", o_error, o_layer_en, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        kcfg = '{4, 4, 4};
        @(negedge clk);
        push_nominal(cyc + 1);
        do_start(t0);
        wait_until(t0 + 12);
        i_start = 1'b1;
        wait_until(t0 + 14);
        i_start = 1'b0;
        n_cmp++;
        if (o_cur_layer !== 2'd2 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_start: cur=%0d busy=%b, required 2/1", o_cur_layer, o_busy);
        end
        wait_until(t0 + 18);
        n_cmp++;
        if (o_busy !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL busy_start_end: busy=%b pending=%0d", o_busy, exp_q.size());
        end
    endtask

    task automatic test_stuck_done();
        int t0;
        kcfg = '{4, 4, 0};
        force_mask = 3'b100;
        @(negedge clk);
        push_ev(cyc + 2,  3'b001, 1'b0);
        push_ev(cyc + 7,  3'b010, 1'b0);
        push_ev(cyc + 12, 3'b100, 1'b0);
        push_ev(cyc + 14, 3'b000, 1'b1);
        do_start(t0);
        wait_until(t0 + 16);
        force_mask = 3'b000;
        n_cmp++;
        if (o_layer_en !== 3'b111 || o_error !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stuck_done_end: en=%b err=%b pending=%0d", o_layer_en, o_error, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        kcfg = '{4, 4, 4};
        @(negedge clk);
        push_ev(cyc + 2, 3'b001, 1'b0);
        push_ev(cyc + 7, 3'b010, 1'b0);
        do_start(t0);
        wait_until(t0 + 8);
        i_reset = 1'b1;
        wait_until(t0 + 9);
        n_cmp++;
        if ({o_layer_en, o_layer_reset, o_cur_layer, o_busy, o_net_done, o_error} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: en=%b rst=%b cur=%0d busy=%b nd=%b err=%b, required all zero",
                     o_layer_en, o_layer_reset, o_cur_layer, o_busy, o_net_done, o_error);
        end
        i_reset = 1'b0;
        wait_until(t0 + 24);
        n_cmp++;
        if (o_busy !== 1'b0 || o_error !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_mid_after: busy=%b err=%b pending=%0d", o_busy, o_error, exp_q.size());
        end
    endtask

    initial begin
        kcfg = '{4, 4, 4};
        test_reset();
        test_nominal();
        test_timeout();
        test_done_timeout_tie();
        test_back_to_back();
        test_stuck_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Controller that runs one inference through a chain of LAYER_NB dense layers, one layer at a time. For each layer it clears the layer, enables it, and waits for that layer's sticky done flag before advancing. It provides a start/busy/done handshake to the top level and a per-layer watchdog timeout. It sits between the top-level inference FSM and the dense_layer instances; it touches no data.

Parameters:
LAYER_NB, 3, number of cascaded dense layers sequenced (>=1)
TIMEOUT, 4096, maximum RUN cycles allowed per layer before error (>=2)
CNT_WIDTH, 16, width of the internal watchdog counter and of cycle_count; must hold TIMEOUT*LAYER_NB+2*LAYER_NB

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin an inference; ignored while busy=1
layer_done  in  LAYER_NB  sticky done flags; bit i from layer i
layer_en  out  LAYER_NB  enable to layer i
layer_reset  out  LAYER_NB  synchronous clear pulse to layer i
cur_layer  out  max(1,$clog2(LAYER_NB))  index of the layer currently being cleared or run
busy  out  1  high from the cycle after start is accepted until DONE or ERROR is entered
net_done  out  1  one-cycle pulse when the last layer completes
error  out  1  sticky timeout flag
cycle_count  out  CNT_WIDTH  (SEQ_PERF_EN only) total cycles of the last inference

Behaviour:
- Reset values: layer_en=0, layer_reset=0, cur_layer=0, busy=0, net_done=0, error=0, cycle_count=0. State=IDLE. Reset mid-operation aborts immediately; no pulses are emitted.
- States: IDLE, CLEAR, RUN, DONE, ERROR. All outputs are registered.
- IDLE/DONE/ERROR + start=1 -> CLEAR with cur_layer=0.
  - layer_en drops to all-zero, error clears, watchdog=0.
  - busy=1 from the next cycle.
- CLEAR (1 cycle):
  - layer_reset[cur_layer]=1; all other bits 0.
  - Next state is RUN.
- RUN:
  - layer_en[j]=1 for every j<=cur_layer, so upstream outputs stay driven; layer_en[j]=0 for j>cur_layer.
  - Watchdog increments each RUN cycle, starting at 1 in the first RUN cycle.
  - layer_done[cur_layer] is sampled only in RUN; layer_done from other layers is ignored.
  - done=1 and cur_layer<LAYER_NB-1: cur_layer++, watchdog=0, go to CLEAR.
  - done=1 and cur_layer==LAYER_NB-1: go to DONE. net_done=1 for exactly that transition cycle; busy=0.
  - done=0 and watchdog==TIMEOUT: go to ERROR. error=1, layer_en=0, busy=0.
  - done and timeout in the same cycle: done wins.
- DONE: layer_en is held at all-ones so outputs stay valid. Outputs are held until the next start or reset.
- ERROR: error is held at 1 and cur_layer holds the failing layer. Exits only on start (which retries from layer 0) or on reset.
- start while busy is ignored with no side effects.
- start in the same cycle as DONE/ERROR entry is ignored; it must arrive in a later cycle.
- Latency: start at cycle T gives layer_reset[0] at T+1 and layer_en[0] at T+2.
  - If every layer asserts done after its k-th RUN cycle, net_done appears LAYER_NB*(k+1) cycles after T+1.
- LAYER_NB=1 is legal; cur_layer is then constantly 0.

Optional Feature:
SEQ_PERF_EN
- Defined: the cycle_count port exists. An internal counter clears on start acceptance and increments every cycle while busy=1. It is latched to cycle_count on entry to DONE or ERROR. cycle_count holds until the next latch or reset, and saturates at all-ones.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- LAYER_NB=3, TIMEOUT=16. start at T0; each layer raises done on its 4th RUN cycle.
  - Required: layer_reset one-hot pulses at T0+1, T0+6, T0+11; net_done=1 at T0+16 only; busy high T0+1..T0+15; layer_en=3'b111 afterwards; with SEQ_PERF_EN, cycle_count=15.
- Layer 1 never asserts done.
  - Required: after 16 RUN cycles of layer 1, error=1, cur_layer=1, layer_en=0, busy=0, no net_done.
  - A later start clears error and restarts at layer 0.
- Layer 0 done and watchdog==16 in the same cycle.
  - Required: advances to CLEAR of layer 1; error stays 0.
- start pulses during RUN of layer 2.
  - Required: no restart; cur_layer stays 2 and completion timing is unchanged.
- layer_done[2] held high from T0.
  - Required: ignored during layers 0 and 1; layer 2 completes on its first RUN cycle.
- reset asserted during RUN of layer 1.
  - Required: next cycle all outputs at reset values; no net_done and no error.
